rr_arbiter16_activelow: RTL and testbench
=========================================

# rr_arbiter16_activelow

Round-robin arbiter that shares the 16-line active-low decoder output bank among 16 requesters. It selects one requester at a time, drives the 4-bit select index and the matching active-low one-hot grant line, and bounds how long a grant is held under contention. It sits in front of the 4x16 active-low decoder path and is the only block that sequences which output line is driven low.

## Interface
- MAX_HOLD, 8: maximum grant length in cycles while another requester is pending (legal range 2..255)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
- en_n  input  1  active-low enable; high blocks new grants and revokes the current one
- req  input  16  request per requester, active-high, level-sensitive
- gnt_n  output  16  one-hot active-low grant; all-ones when nothing is granted
- gnt_idx  output  4  index of the granted requester; valid only while gnt_valid=1
- gnt_valid  output  1  high while a grant is active

## Operation
- All outputs are registered. Internal state consists of `state` (IDLE/GRANT), `ptr[3:0]` (highest-priority index), `idx[3:0]`, and `cnt[7:0]`.
- Reset (rst_n=0 at an edge): state=IDLE, ptr=0, cnt=0, gnt_n=16'hFFFF, gnt_idx=0, gnt_valid=0. Reset takes priority over every other condition, including a grant in progress.
- IDLE:
  - If en_n=0 and req≠0, choose the first set bit searching ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
  - Next edge: state=GRANT, idx=chosen, cnt=0, gnt_valid=1, gnt_idx=chosen, gnt_n=~(16'h1<<chosen).
  - Otherwise stay in IDLE with outputs at their reset values. ptr does not change.
- GRANT: "others" means any req bit set other than req[idx]. The grant is released at the next edge if any of the following holds:
  - (a) req[idx]=0
  - (b) en_n=1
  - (c) cnt==MAX_HOLD-1 and others≠0
- Otherwise stay in GRANT and set cnt=cnt+1, saturating at MAX_HOLD-1.
- Release: next edge sets state=IDLE, gnt_n=16'hFFFF, gnt_valid=0, gnt_idx=0, cnt=0, ptr=idx+1 (4-bit wrap, so 15→0).
- Uncontended holder: with others=0 the grant persists indefinitely; cnt saturates and does not force a release.
- Preemption at saturation: if cnt is saturated and another requester then asserts, release happens at the next edge (condition c).
- Simultaneous events: if several release conditions hold together, the result is a single release with the same effect. A requester that releases and re-requests is served again only after every other pending requester ahead of it in rotation.
- Invariant: gnt_n has at most one zero bit in every cycle.

## Timing
- Request to grant: a req sampled high in IDLE at edge N appears on gnt_n after edge N+1 (1-cycle latency).
- Release: a release condition sampled at edge N means gnt_n=16'hFFFF after edge N+1.
- Dead cycle: there is always at least one IDLE cycle, with all gnt_n high, between two grants (break-before-make on decoder lines). Best-case back-to-back turnaround is 2 cycles.
- Contended grant length: exactly MAX_HOLD cycles when the holder keeps requesting.
- Worst-case wait for a continuously requesting line: 15×(MAX_HOLD+1) cycles.
- gnt_idx and gnt_valid change on the same edge as gnt_n; no combinational path from inputs to outputs.

## Test plan
- Reset mid-grant:
  - Stimulus: req=16'h0010 until grant, then rst_n=0 for 1 edge.
  - Required: gnt_n=16'hFFFF, gnt_valid=0 after that edge; ptr=0, so req=16'h0011 next grants idx 0.
- Single requester:
  - Stimulus: from reset, req=16'h0008.
  - Required: one edge later gnt_n=16'hFFF7, gnt_idx=3, gnt_valid=1. After req drops: gnt_n=16'hFFFF one edge later.
- Round-robin rotation:
  - Stimulus: req=16'h8001 held, MAX_HOLD=8.
  - Required: grants alternate idx 0 (8 cycles), dead cycle, idx 15 (8 cycles), dead cycle, idx 0, and so on.
- Wrap-around:
  - Stimulus: ptr=15 after serving idx 14; req=16'h4003.
  - Required: next grant is idx 0, then idx 1, then idx 14.
- Uncontended hold:
  - Stimulus: req=16'h0100 held for 40 cycles.
  - Required: gnt_n=16'hFEFF for all 40 cycles with no release.
  - Stimulus continued: at cycle 41 assert req[2].
  - Required: release one edge later, dead cycle, then gnt_idx=2.
- Enable:
  - Stimulus: en_n=1 with req=16'hFFFF.
  - Required: gnt_n stays 16'hFFFF.
  - Stimulus continued: en_n=1 during a grant.
  - Required: release at the next edge and ptr advances.
  - Stimulus continued: en_n=0.
  - Required: grant after 1 cycle.

Source files
------------

// File: rtl/rr_arbiter16_activelow.sv
// Round-robin arbiter for 16 requesters driving a one-hot active-low grant bank.
// A grant is held for at most MAX_HOLD cycles under contention, with one idle cycle between grants.
module rr_arbiter16_activelow #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_n,
  input  logic [15:0] req,
  output logic [15:0] gnt_n,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid
);

  localparam logic [7:0] CNT_MAX = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_d;
  logic [3:0]  ptr, ptr_d;
  logic [3:0]  idx, idx_d;
  logic [7:0]  cnt, cnt_d;
  logic [15:0] gnt_n_d;
  logic [3:0]  gnt_idx_d;
  logic        gnt_valid_d;

  logic        found;
  logic [3:0]  pick;
  logic [3:0]  cand;
  logic        others;
  logic        release_now;

  // Rotating priority search: the first set request at or after ptr, wrapping at 16.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign others      = |(req & ~(16'h0001 << idx));
  assign release_now = !req[idx] || en_n || ((cnt == CNT_MAX) && others);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state;
    ptr_d       = ptr;
    idx_d       = idx;
    cnt_d       = cnt;
    gnt_n_d     = 16'hFFFF;
    gnt_idx_d   = 4'd0;
    gnt_valid_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (!en_n && found) begin
          state_d     = GRANT;
          idx_d       = pick;
          cnt_d       = 8'd0;
          gnt_n_d     = ~(16'h0001 << pick);
          gnt_idx_d   = pick;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          ptr_d   = idx + 4'd1;
        end else begin
          // Saturate so an uncontended holder keeps its grant indefinitely.
          cnt_d       = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
          gnt_n_d     = ~(16'h0001 << idx);
          gnt_idx_d   = idx;
          gnt_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 4'd0;
      idx       <= 4'd0;
      cnt       <= 8'd0;
      gnt_n     <= 16'hFFFF;
      gnt_idx   <= 4'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      gnt_n     <= gnt_n_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter16_activelow.sv
// Self-checking bench for rr_arbiter16_activelow: directed vectors, hand sequences,
// and random stimulus against a behavioural model of the round-robin rules.
module tb_rr_arbiter16_activelow;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst_n;
  logic        en_n;
  logic [15:0] req;
  logic [15:0] gnt_n;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;

  int vectors = 0;
  int miscompares = 0;

  rr_arbiter16_activelow #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_n      (en_n),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who holds the line, for how many cycles, and where the rotation starts.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_held;

  task automatic model_step();
    bit [15:0] others;
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0;
    end else if (!m_valid) begin
      if (!en_n && req != 16'h0) begin
        for (int i = 0; i < 16; i++) begin
          if (req[(m_ptr + i) % 16]) begin
            m_idx = (m_ptr + i) % 16;
            break;
          end
        end
        m_valid = 1;
        m_held  = 1;
      end
    end else begin
      others = req;
      others[m_idx] = 1'b0;
      if (!req[m_idx] || en_n || (others != 0 && m_held >= MAX_HOLD)) begin
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 16;
        m_idx   = 0;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp_gnt_n,
                       input logic [3:0] exp_idx, input logic exp_valid);
    vectors++;
    if (gnt_n !== exp_gnt_n || gnt_idx !== exp_idx || gnt_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL %s: got gnt_n=%h gnt_idx=%0d gnt_valid=%b, want gnt_n=%h gnt_idx=%0d gnt_valid=%b",
               name, gnt_n, gnt_idx, gnt_valid, exp_gnt_n, exp_idx, exp_valid);
    end
  endtask

  task automatic check_model(input string name);
    logic [15:0] eg;
    logic [3:0]  ei;
    eg = m_valid ? ~(16'h0001 << m_idx) : 16'hFFFF;
    ei = m_valid ? 4'(m_idx) : 4'd0;
    check(name, eg, ei, m_valid);
  endtask

  typedef struct {
    logic        rst_n;
    logic        en_n;
    logic [15:0] req;
    logic [15:0] gnt_n;
    logic [3:0]  idx;
    logic        valid;
  } vec_t;

  vec_t vecs[23];

  initial begin
    rst_n = 1'b0;
    en_n  = 1'b1;
    req   = 16'h0;

    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 4'd0,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 4'd0,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0008, 16'hFFF7, 4'd3,  1'b1};
    vecs[3]  = '{1'b1, 1'b0, 16'h0008, 16'hFFF7, 4'd3,  1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 4'd0,  1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0010, 16'hFFEF, 4'd4,  1'b1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0010, 16'hFFFF, 4'd0,  1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0011, 16'hFFFE, 4'd0,  1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 4'd0,  1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 4'd0,  1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 4'd0,  1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFD, 4'd1,  1'b1};
    vecs[12] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 4'd0,  1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFB, 4'd2,  1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 4'd0,  1'b0};
    vecs[15] = '{1'b1, 1'b0, 16'h4000, 16'hBFFF, 4'd14, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 4'd0,  1'b0};
    vecs[17] = '{1'b1, 1'b0, 16'h4003, 16'hFFFE, 4'd0,  1'b1};
    vecs[18] = '{1'b1, 1'b0, 16'h4002, 16'hFFFF, 4'd0,  1'b0};
    vecs[19] = '{1'b1, 1'b0, 16'h4002, 16'hFFFD, 4'd1,  1'b1};
    vecs[20] = '{1'b1, 1'b0, 16'h4000, 16'hFFFF, 4'd0,  1'b0};
    vecs[21] = '{1'b1, 1'b0, 16'h4000, 16'hBFFF, 4'd14, 1'b1};
    vecs[22] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 4'd0,  1'b0};

    for (int i = 0; i < 23; i++) begin
      rst_n = vecs[i].rst_n;
      en_n  = vecs[i].en_n;
      req   = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), vecs[i].gnt_n, vecs[i].idx, vecs[i].valid);
    end

    // Rotation between idx 0 and 15: 8-cycle grants separated by one dead cycle.
    rst_n = 1'b0; en_n = 1'b0; req = 16'h0;
    tick();
    check("rot_reset", 16'hFFFF, 4'd0, 1'b0);
    rst_n = 1'b1;
    req   = 16'h8001;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        if (r % 2 == 0) check($sformatf("rot%0d_c%0d", r, c), 16'hFFFE, 4'd0, 1'b1);
        else            check($sformatf("rot%0d_c%0d", r, c), 16'h7FFF, 4'd15, 1'b1);
      end
      tick();
      check($sformatf("rot%0d_dead", r), 16'hFFFF, 4'd0, 1'b0);
    end
    req = 16'h0;
    tick();
    check("rot_idle", 16'hFFFF, 4'd0, 1'b0);

    // Uncontended holder keeps the line; a late competitor forces release then gets served.
    req = 16'h0100;
    for (int c = 0; c < 41; c++) begin
      tick();
      check($sformatf("hold_c%0d", c), 16'hFEFF, 4'd8, 1'b1);
    end
    req = 16'h0104;
    tick();
    check("preempt_release", 16'hFFFF, 4'd0, 1'b0);
    tick();
    check("preempt_grant", 16'hFFFB, 4'd2, 1'b1);
    req = 16'h0;
    tick();
    check("preempt_idle", 16'hFFFF, 4'd0, 1'b0);

    // Random stimulus against the model; requests are sticky so holds and saturation occur.
    rst_n = 1'b0; en_n = 1'b0; req = 16'h0;
    tick();
    check_model("rnd_reset");
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      end
      en_n  = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
